// File: rtl/arm_cond_ctrl_pkg.sv
// Shared types for the ARM conditional-execution controller: condition codes,
// sequencer states, NZCV bit positions and the wait-counter sizing helper.
package arm_ctrl_pkg;

   typedef enum logic [3:0] {
      EQ = 4'h0, NE, CS, CC, MI, PL, VS, VC,
      HI, LS, GE, LT, GT, LE, AL, NV
   } cond_e;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } ctrl_state_e;

   localparam int N = 3;
   localparam int Z = 2;
   localparam int C = 1;
   localparam int V = 0;

   // Counter must hold the larger of the two terminal counts without wrapping.
   function automatic int cnt_width(input int lat, input int tmo);
      int m;
      m = (lat > tmo) ? lat : tmo;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/arm_cond_ctrl_if.sv
// Decoder-side and datapath-side signals of the conditional controller.
// slave: the controller itself; master: whatever drives the decoder fields.
interface arm_cond_ctrl_if;

   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS_from_decoder;
   logic       RegW_from_decoder;
   logic       MemW_from_decoder;
   logic       MemtoReg;
   logic       NoWrite;
   logic       MemAck;

   logic       PCSrc;
   logic       RegWrite;
   logic       MemWrite;
   logic       MemReq;
   logic       Stall;
   logic       Fault;
   logic       CondEx;
   logic [3:0] Flags;

   modport slave (
      input  Cond, ALUFlags, FlagW, PCS_from_decoder, RegW_from_decoder,
             MemW_from_decoder, MemtoReg, NoWrite, MemAck,
      output PCSrc, RegWrite, MemWrite, MemReq, Stall, Fault, CondEx, Flags
   );

   modport master (
      output Cond, ALUFlags, FlagW, PCS_from_decoder, RegW_from_decoder,
             MemW_from_decoder, MemtoReg, NoWrite, MemAck,
      input  PCSrc, RegWrite, MemWrite, MemReq, Stall, Fault, CondEx, Flags
   );

endinterface

// File: rtl/arm_cond_check.sv
// ARM condition-code evaluator: Cond + NZCV -> pass/fail, purely combinational.
// Zero latency, no handshake; 1111 is treated as never-execute.
module arm_cond_check
   import arm_ctrl_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       cond_ex
);

   logic n, z, c, v;

   always_comb begin
      n = flags[N];
      z = flags[Z];
      c = flags[C];
      v = flags[V];
      cond_ex = 1'b0;
      unique case (cond_e'(cond))
         EQ: cond_ex = z;
         NE: cond_ex = ~z;
         CS: cond_ex = c;
         CC: cond_ex = ~c;
         MI: cond_ex = n;
         PL: cond_ex = ~n;
         VS: cond_ex = v;
         VC: cond_ex = ~v;
         HI: cond_ex = c & ~z;
         LS: cond_ex = ~c | z;
         GE: cond_ex = ~(n ^ v);
         LT: cond_ex = n ^ v;
         GT: cond_ex = ~z & ~(n ^ v);
         LE: cond_ex = z | (n ^ v);
         AL: cond_ex = 1'b1;
         NV: cond_ex = 1'b0;
      endcase
   end

endmodule

// File: rtl/arm_cond_ctrl.sv
// Gates decoder writes by condition and sequences multi-cycle memory accesses.
// Non-memory ops commit in one cycle; memory ops hold Stall for MEM_LATENCY or until MemAck/timeout.
module arm_cond_ctrl
   import arm_ctrl_pkg::*;
#(
   parameter int MEM_LATENCY = 2,
   parameter int USE_ACK     = 0,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic           clk,
   input  logic           reset,
   arm_cond_ctrl_if.slave bus
);

   localparam int CW = cnt_width(MEM_LATENCY, ACK_TIMEOUT);
   localparam logic [CW-1:0] LAT_C = CW'(MEM_LATENCY);
   localparam logic [CW-1:0] TMO_C = CW'(ACK_TIMEOUT);
   localparam bit NEED_WAIT = (USE_ACK != 0) || (MEM_LATENCY > 0);

   ctrl_state_e   state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [3:0]    flags, flags_nxt;

   logic cond_ex;
   logic mem_op;
   logic commit;
   logic stall;
   logic mem_req;
   logic fault;

   arm_cond_check u_cond_check (
      .cond    (bus.Cond),
      .flags   (flags),
      .cond_ex (cond_ex)
   );

   assign mem_op = cond_ex & (bus.MemW_from_decoder | bus.MemtoReg);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         flags <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         flags <= flags_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      commit    = 1'b0;
      stall     = 1'b0;
      mem_req   = 1'b0;
      fault     = 1'b0;
      unique case (state)
         IDLE: begin
            if (mem_op && NEED_WAIT) begin
               stall     = 1'b1;
               mem_req   = 1'b1;
               cnt_nxt   = CW'(1);
               state_nxt = WAIT;
            end else begin
               commit  = 1'b1;
               mem_req = mem_op;
            end
         end
         WAIT: begin
            mem_req = 1'b1;
            if (USE_ACK != 0) begin
               if (bus.MemAck) begin
                  commit    = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end else if (cnt >= TMO_C) begin
                  // Abandon the access: no writes and no flag update this cycle.
                  fault     = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  stall   = 1'b1;
                  cnt_nxt = cnt + CW'(1);
               end
            end else begin
               if (cnt >= LAT_C) begin
                  commit    = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  stall   = 1'b1;
                  cnt_nxt = cnt + CW'(1);
               end
            end
         end
      endcase
   end

   always_comb begin
      flags_nxt = flags;
      if (commit && cond_ex) begin
         if (bus.FlagW[1]) flags_nxt[N:Z] = bus.ALUFlags[N:Z];
         if (bus.FlagW[0]) flags_nxt[C:V] = bus.ALUFlags[C:V];
      end
   end

   // Every output is forced low while reset is held, independent of the clock.
   assign bus.PCSrc    = ~reset & commit & bus.PCS_from_decoder & cond_ex;
   assign bus.RegWrite = ~reset & commit & bus.RegW_from_decoder & cond_ex & ~bus.NoWrite;
   assign bus.MemWrite = ~reset & commit & bus.MemW_from_decoder & cond_ex;
   assign bus.MemReq   = ~reset & mem_req;
   assign bus.Stall    = ~reset & stall;
   assign bus.Fault    = ~reset & fault;
   assign bus.CondEx   = ~reset & cond_ex;
   assign bus.Flags    = flags;

   a_no_fault_with_stall: assert property (
      @(posedge clk) disable iff (reset) !(bus.Fault && bus.Stall));

   a_inputs_held_in_stall: assert property (
      @(posedge clk) disable iff (reset)
      bus.Stall |=> $stable({bus.Cond, bus.ALUFlags, bus.FlagW, bus.PCS_from_decoder,
                             bus.RegW_from_decoder, bus.MemW_from_decoder,
                             bus.MemtoReg, bus.NoWrite}));

endmodule

// File: doc/arm_cond_ctrl.md
Name: arm_cond_ctrl

Overview:
Parametrised successor to the existing conditional-logic controller for the ARM core. It evaluates all ARM condition codes against an architectural NZCV register and gates the decoder's RegWrite/MemWrite/PCS. It also adds a multi-cycle memory-access sequencer that drives Stall, either for a fixed latency or until a memory acknowledge arrives, with timeout fault reporting. It sits between the decoder and the datapath/mem_map in the arm top level.

Parameters:
MEM_LATENCY, 2, extra cycles a memory op stalls when USE_ACK=0 (0 = single-cycle, no stall)
USE_ACK, 0, 1 = hold the access until MemAck instead of counting MEM_LATENCY
ACK_TIMEOUT, 15, maximum wait cycles in ACK mode before the access is aborted (>=1)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
Cond  in  4  Instr[31:28]
ALUFlags  in  4  {N,Z,C,V} from the ALU for the current instruction
FlagW  in  2  [1]=update N,Z; [0]=update C,V
PCS_from_decoder  in  1  instruction writes PC
RegW_from_decoder  in  1  instruction writes the register file
MemW_from_decoder  in  1  store
MemtoReg  in  1  load
NoWrite  in  1  compare-class op; suppresses RegWrite
MemAck  in  1  memory completion (used only when USE_ACK=1)
PCSrc  out  1  gated PC write
RegWrite  out  1  gated register write
MemWrite  out  1  gated store strobe
MemReq  out  1  memory access in progress
Stall  out  1  hold PC and instruction
Fault  out  1  one-cycle pulse on access timeout
CondEx  out  1  condition passed for current instruction
Flags  out  4  architectural NZCV register

Behaviour:
- Reset (async, high): Flags=0, state IDLE, counter=0. While reset is high, all outputs are 0.
- CondEx is combinational from Cond and Flags: EQ..LE per ARM, AL(1110)=1, 1111=0 (never).
- MemOp = CondEx & (MemW_from_decoder | MemtoReg). Non-memory instructions and failed-condition instructions complete in one cycle with no stall.
- A commit cycle is any cycle with state IDLE and not (MemOp & stall required), or the final cycle of a WAIT. Only commit cycles may assert PCSrc, RegWrite, MemWrite, or update Flags.
- At commit:
  - PCSrc = PCS & CondEx
  - RegWrite = RegW & CondEx & ~NoWrite
  - MemWrite = MemW & CondEx
  - Flags[3:2] <= ALUFlags[3:2] if FlagW[1] & CondEx
  - Flags[1:0] <= ALUFlags[1:0] if FlagW[0] & CondEx
- FSM states: IDLE, WAIT.
- IDLE:
  - If MemOp and (USE_ACK=1 or MEM_LATENCY>0): Stall=1, MemReq=1, counter<=1, go to WAIT.
  - Otherwise: commit, with MemReq = MemOp.
- WAIT, fixed mode: Stall=1 while counter<MEM_LATENCY, incrementing each cycle. The cycle with counter==MEM_LATENCY is the commit cycle: Stall=0, MemReq=1. Then return to IDLE. Total cycles for the instruction = MEM_LATENCY+1.
- WAIT, ACK mode:
  - MemAck=1: commit this cycle (Stall=0), return to IDLE.
  - MemAck=0 and counter==ACK_TIMEOUT: abort. Stall=0, Fault=1, no writes, no flag update, return to IDLE.
  - Otherwise: Stall=1, counter++.
- MemAck in IDLE is ignored. Inputs are held stable by the datapath while Stall=1.
- Flags never change during WAIT, so CondEx is stable across the access.
- Counter width is $clog2(max(MEM_LATENCY,ACK_TIMEOUT)+1). The counter does not wrap.
- Reset mid-WAIT: the access is dropped, no write is issued, and the FSM is in IDLE on the first cycle after release.

Decomposition:
- Package arm_ctrl_pkg:
  - cond_e enum (EQ..AL, NV)
  - ctrl_state_e {IDLE, WAIT}
  - flag index constants N=3, Z=2, C=1, V=0
- One combinational sub-module, arm_cond_check (Cond, Flags -> CondEx), reused by the planned pipelined core.

Test Plan:
- Flags=4'b0100 (Z=1): Cond=0000(EQ) -> CondEx=1; Cond=0001(NE) -> 0; Cond=1111 -> 0; Cond=1110 -> 1 for any Flags.
- Flags=0, ALUFlags=1111, FlagW=10, Cond=AL -> next Flags=1100. Then FlagW=01 with ALUFlags=0000 -> Flags=1100 (C,V already 0). FlagW=11 with Cond=EQ failing -> Flags unchanged.
- MEM_LATENCY=2, load, Cond=AL:
  - cycle0 Stall=1, MemReq=1, RegWrite=0
  - cycle1 Stall=1, RegWrite=0
  - cycle2 Stall=0, RegWrite=1
  - cycle3 IDLE
- MEM_LATENCY=2, store -> MemWrite=1 only in cycle2, exactly one pulse. Same store with Cond failing -> no Stall, no MemReq, no MemWrite.
- USE_ACK=1, ACK_TIMEOUT=3:
  - MemAck raised in cycle2 -> commit that cycle.
  - No MemAck -> Stall high for cycles0-2, cycle3 Fault=1, Stall=0, MemWrite=0, then IDLE.
- Reset asserted during cycle1 of a WAIT -> all outputs 0 immediately. After release, a new ALU instruction commits in one cycle with Stall=0.
